// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and constants for the 4x4 matrix keypad scanner.
//   - db_state_e    : debounce FSM states
//   - frame_class_e : classification of one full 16-bit scan frame
//   - frame_info_t  : classification plus index of the single pressed key
//   - classify_frame: reduces a frame snapshot to frame_info_t
package keypad_pkg;

    localparam int KEY_W    = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int FRAME_W  = NUM_ROWS * NUM_COLS;

    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } db_state_e;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_class_e;

    typedef struct packed {
        frame_class_e       cls;
        logic [KEY_W-1:0]   idx;
    } frame_info_t;

    // Count set bits (saturating at two) and remember the first set index;
    // idx is only meaningful when cls is SINGLE.
    function automatic frame_info_t classify_frame(input logic [FRAME_W-1:0] snap);
        frame_info_t info;
        logic [1:0]  hits;
        info.idx = 4'd0;
        hits     = 2'd0;
        for (int b = 0; b < FRAME_W; b++) begin
            if (snap[b]) begin
                if (hits == 2'd0) begin
                    info.idx = KEY_W'(b);
                    hits     = 2'd1;
                end else begin
                    hits     = 2'd2;
                end
            end
        end
        case (hits)
            2'd0:    info.cls = NONE;
            2'd1:    info.cls = SINGLE;
            default: info.cls = MULTI;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/keypad_scan_debounce.sv
// keypad_debounce
// Frame-rate debounce FSM for the keypad scanner. Evaluated only on
// frame_end; accepts a press after DEBOUNCE_CNT identical SINGLE frames and a
// release after DEBOUNCE_CNT NONE frames. No rollover: a new key is accepted
// only after a full release.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat every REPEAT_FRAMES
// frames while HELD).
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   frame_end       - one-cycle strobe, frame_class/frame_idx valid
//   frame_class     - frame_class_e encoding of the finished frame
//   frame_idx       - index of the pressed key for SINGLE frames
//   key_code        - last accepted key
//   key_valid       - one-cycle strobe on acceptance (or repeat)
//   key_down        - high while in HELD or RELEASE_DB
//   prev_code       - key_code before the most recent acceptance
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CNT  = 4,
    parameter int REPEAT_FRAMES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_end,
    input  logic [1:0]       frame_class,
    input  logic [KEY_W-1:0] frame_idx,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_down,
    output logic [KEY_W-1:0] prev_code
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);

    if (DEBOUNCE_CNT < 1 || REPEAT_FRAMES < 1) begin : g_bad_param
        $error("keypad_debounce: DEBOUNCE_CNT and REPEAT_FRAMES must be >= 1");
    end

    frame_class_e      cls_s;
    db_state_e         state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [KEY_W-1:0]  cand_r, cand_nxt_s;
    logic [KEY_W-1:0]  key_code_r, code_nxt_s;
    logic [KEY_W-1:0]  prev_code_r, prev_nxt_s;
    logic              key_valid_r, key_down_r;
    logic              accept_s;
    logic [KEY_W-1:0]  accept_code_s;
    logic              repeat_s;

    assign cls_s     = frame_class_e'(frame_class);
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + CNT_ONE;

    // Debounce next-state logic, only advanced on a frame end.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        cand_nxt_s    = cand_r;
        code_nxt_s    = key_code_r;
        prev_nxt_s    = prev_code_r;
        accept_s      = 1'b0;
        accept_code_s = cand_r;
        if (frame_end) begin
            case (state_r)
                IDLE: begin
                    if (cls_s == SINGLE) begin
                        if (CNT_MAX == CNT_ONE) begin
                            accept_s      = 1'b1;
                            accept_code_s = frame_idx;
                        end else begin
                            cand_nxt_s  = frame_idx;
                            cnt_nxt_s   = CNT_ONE;
                            state_nxt_s = PRESS_DB;
                        end
                    end else begin
                        cnt_nxt_s = CNT_ZERO;
                    end
                end
                PRESS_DB: begin
                    if (cls_s == SINGLE && frame_idx == cand_r) begin
                        if (cnt_inc_s == CNT_MAX) begin
                            accept_s      = 1'b1;
                            accept_code_s = cand_r;
                        end else begin
                            cnt_nxt_s = cnt_inc_s;
                        end
                    end else if (cls_s == SINGLE) begin
                        cand_nxt_s = frame_idx;
                        cnt_nxt_s  = CNT_ONE;
                    end else begin
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = IDLE;
                    end
                end
                HELD: begin
                    // MULTI and SINGLE(other) deliberately keep the held key.
                    if (cls_s == NONE) begin
                        if (CNT_MAX == CNT_ONE) begin
                            cnt_nxt_s   = CNT_ZERO;
                            state_nxt_s = IDLE;
                        end else begin
                            cnt_nxt_s   = CNT_ONE;
                            state_nxt_s = RELEASE_DB;
                        end
                    end else begin
                        state_nxt_s = HELD;
                    end
                end
                RELEASE_DB: begin
                    if (cls_s == NONE) begin
                        if (cnt_inc_s == CNT_MAX) begin
                            cnt_nxt_s   = CNT_ZERO;
                            state_nxt_s = IDLE;
                        end else begin
                            cnt_nxt_s = cnt_inc_s;
                        end
                    end else if (cls_s == SINGLE && frame_idx == key_code_r) begin
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = HELD;
                    end else begin
                        cnt_nxt_s = CNT_ZERO;
                    end
                end
                default: begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
        if (accept_s) begin
            state_nxt_s = HELD;
            cnt_nxt_s   = CNT_ZERO;
            prev_nxt_s  = key_code_r;
            code_nxt_s  = accept_code_s;
        end else begin
            prev_nxt_s  = prev_code_r;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int              REP_W    = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
    localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REPEAT_FRAMES);

    logic [REP_W-1:0] rep_cnt_r, rep_cnt_nxt_s;

    // Repeat frame counter: runs only while staying in HELD.
    always_comb begin
        rep_cnt_nxt_s = rep_cnt_r;
        repeat_s      = 1'b0;
        if (accept_s || state_nxt_s != HELD) begin
            rep_cnt_nxt_s = REP_ZERO;
        end else if (frame_end && state_r == HELD) begin
            if (rep_cnt_r + REP_ONE >= REP_MAX) begin
                repeat_s      = 1'b1;
                rep_cnt_nxt_s = REP_ZERO;
            end else begin
                rep_cnt_nxt_s = rep_cnt_r + REP_ONE;
            end
        end else begin
            rep_cnt_nxt_s = rep_cnt_r;
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt_r <= REP_ZERO;
        end else begin
            rep_cnt_r <= rep_cnt_nxt_s;
        end
    end
`else
    assign repeat_s = 1'b0;
`endif

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            cand_r      <= 4'd0;
            key_code_r  <= 4'd0;
            prev_code_r <= 4'd0;
            key_valid_r <= 1'b0;
            key_down_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            cand_r      <= cand_nxt_s;
            key_code_r  <= code_nxt_s;
            prev_code_r <= prev_nxt_s;
            key_valid_r <= accept_s | repeat_s;
            key_down_r  <= (state_nxt_s == HELD) || (state_nxt_s == RELEASE_DB);
        end
    end

    assign key_code  = key_code_r;
    assign prev_code = prev_code_r;
    assign key_valid = key_valid_r;
    assign key_down  = key_down_r;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
// Scans a 4x4 active-low matrix keypad, synchronizes the rows, builds a
// 16-bit frame snapshot (bit = row*4 + col) and hands each completed frame to
// keypad_debounce, which reports new presses as a hex code plus strobe.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat while held).
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset
//   col_n[3:0] - column drive, active-low, one bit low at a time
//   row_n[3:0] - row sense, active-low, asynchronous to clk
//   key_code   - last accepted key (row*4 + col)
//   key_valid  - one-cycle strobe when key_code is (re)issued
//   key_down   - high while the accepted key is held
//   prev_code  - key_code value before the most recent new acceptance
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV      = 50000,
    parameter int DEBOUNCE_CNT  = 4,
    parameter int REPEAT_FRAMES = 64
) (
    input  logic                clk,
    input  logic                reset,
    output logic [NUM_COLS-1:0] col_n,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_valid,
    output logic                key_down,
    output logic [KEY_W-1:0]    prev_code
);

    localparam int               SLOT_W    = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam int               COL_W     = $clog2(NUM_COLS);
    localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_COLS - 1);

    if (SCAN_DIV < 4) begin : g_bad_param
        $error("keypad_scan: SCAN_DIV must be >= 4");
    end

    logic [NUM_ROWS-1:0] row_meta_r, row_sync_r;
    logic [SLOT_W-1:0]   slot_r;
    logic [COL_W-1:0]    col_idx_r;
    logic [NUM_COLS-1:0] col_n_r;
    logic [FRAME_W-1:0]  snap_r, snap_nxt_s;
    logic                sample_s, frame_end_s;
    frame_info_t         info_s;

    // Two-flop row synchronizer; idles high like the pulled-up pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_r <= 4'b1111;
            row_sync_r <= 4'b1111;
        end else begin
            row_meta_r <= row_n;
            row_sync_r <= row_meta_r;
        end
    end

    // Slot and column counters; col_n rotates together with col_idx.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_r    <= {SLOT_W{1'b0}};
            col_idx_r <= {COL_W{1'b0}};
            col_n_r   <= COL_RESET;
        end else if (slot_r == SLOT_LAST) begin
            slot_r    <= {SLOT_W{1'b0}};
            col_idx_r <= col_idx_r + COL_ONE;
            col_n_r   <= {col_n_r[NUM_COLS-2:0], col_n_r[NUM_COLS-1]};
        end else begin
            slot_r    <= slot_r + SLOT_ONE;
        end
    end

    // Sampling in the last slot cycle leaves the synchronizer time to settle
    // after the column change.
    assign sample_s    = (slot_r == SLOT_LAST);
    assign frame_end_s = sample_s && (col_idx_r == COL_LAST);

    // Snapshot with the current column's rows merged in, so the frame-end
    // classification sees the column being sampled this cycle.
    always_comb begin
        snap_nxt_s = snap_r;
        for (int b = 0; b < FRAME_W; b++) begin
            if (col_idx_r == COL_W'(b % NUM_COLS)) begin
                snap_nxt_s[b] = ~row_sync_r[b / NUM_COLS];
            end else begin
                snap_nxt_s[b] = snap_r[b];
            end
        end
    end

    // Frame snapshot register.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_r <= {FRAME_W{1'b0}};
        end else if (sample_s) begin
            snap_r <= snap_nxt_s;
        end else begin
            snap_r <= snap_r;
        end
    end

    // Frame classification for the debounce FSM.
    always_comb begin
        info_s = classify_frame(snap_nxt_s);
    end

    keypad_debounce #(
        .DEBOUNCE_CNT  (DEBOUNCE_CNT),
        .REPEAT_FRAMES (REPEAT_FRAMES)
    ) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .frame_end   (frame_end_s),
        .frame_class (info_s.cls),
        .frame_idx   (info_s.idx),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_down    (key_down),
        .prev_code   (prev_code)
    );

    assign col_n = col_n_r;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=3,
// REPEAT_FRAMES=2 (16-cycle frames). A behavioural matrix drives row_n from
// the pressed-key set and col_n. Times are expressed as edges since reset
// release; frame k ends on edge 16*k.
module tb_keypad_scan;

    localparam logic [15:0] K3  = 16'h0008;
    localparam logic [15:0] K6  = 16'h0040;
    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K12 = 16'h1000;

    logic        clk;
    logic        reset;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [3:0]  prev_code;
    logic [15:0] keys;

    int n_assert;
    int n_fail;
    int cyc;
    int strobes;

    keypad_scan #(
        .SCAN_DIV      (4),
        .DEBOUNCE_CNT  (3),
        .REPEAT_FRAMES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .prev_code (prev_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low when its column is driven.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col_n[c] && keys[r*4 + c]) row_n[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    initial strobes = 0;
    always @(negedge clk) if (!reset && key_valid) strobes <= strobes + 1;

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp_v);
        n_assert++;
        assert (obs == exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance to 1 time unit after edge e (edges counted from reset release).
    task automatic wait_edge(input int e);
        int guard;
        guard = 0;
        while (cyc < e && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc < e) begin
            n_assert++;
            n_fail++;
            $error("FAIL wait_edge: reached edge %0d required %0d", cyc, e);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        keys     = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk4("rst_col_n", col_n, 4'b1110);
        chk4("rst_key_code", key_code, 4'd0);
        chk4("rst_prev_code", prev_code, 4'd0);
        chk1("rst_key_valid", key_valid, 1'b0);
        chk1("rst_key_down", key_down, 1'b0);
        reset = 1'b0;

        // Column stepping.
        wait_edge(3);   chk4("col_slot0", col_n, 4'b1110);
        wait_edge(4);   chk4("col_1", col_n, 4'b1101);
        wait_edge(8);   chk4("col_2", col_n, 4'b1011);
        wait_edge(12);  chk4("col_3", col_n, 4'b0111);
        wait_edge(16);  chk4("col_wrap", col_n, 4'b1110);
        chk1("idle_valid", key_valid, 1'b0);

        // Clean press of code 6: accepted on the 3rd frame end (edge 64).
        keys = K6;
        wait_edge(63);  chk1("press_early_valid", key_valid, 1'b0);
        chk1("press_early_down", key_down, 1'b0);
        wait_edge(64);  chk1("press_valid", key_valid, 1'b1);
        chk4("press_code", key_code, 4'd6);
        chk4("press_prev", prev_code, 4'd0);
        chk1("press_down", key_down, 1'b1);
        wait_edge(65);  chk1("press_valid_1cyc", key_valid, 1'b0);
        chk1("press_down_held", key_down, 1'b1);

        // Rollover: add 9 (MULTI), then only 9 (SINGLE other) while holding 6.
        wait_edge(80);  keys = K6 | K9;
        wait_edge(96);  keys = K9;
        wait_edge(112); chk4("rollover_code", key_code, 4'd6);
        chk1("rollover_down", key_down, 1'b1);
        chki("rollover_strobes", strobes, 1);

        // Release: three NONE frames, accepted on edge 160.
        keys = 16'h0000;
        wait_edge(159); chk1("release_down_held", key_down, 1'b1);
        wait_edge(160); chk1("release_down_fall", key_down, 1'b0);
        chki("release_strobes", strobes, 1);

        // Next key 9.
        keys = K9;
        wait_edge(207); chk1("key9_early_valid", key_valid, 1'b0);
        wait_edge(208); chk1("key9_valid", key_valid, 1'b1);
        chk4("key9_code", key_code, 4'd9);
        chk4("key9_prev", prev_code, 4'd6);
        keys = 16'h0000;
        wait_edge(256); chk1("key9_released", key_down, 1'b0);

        // Multi-key press from IDLE is ignored.
        keys = K3 | K12;
        wait_edge(320); chki("multi_strobes", strobes, 2);
        chk1("multi_down", key_down, 1'b0);
        chk4("multi_code", key_code, 4'd9);

        // Bounce: two frames of 6, one NONE frame, then three frames of 6.
        keys = K6;
        wait_edge(352); keys = 16'h0000;
        wait_edge(368); keys = K6;
        wait_edge(400); chk1("bounce_no_early", key_valid, 1'b0);
        chki("bounce_strobes_before", strobes, 2);
        wait_edge(416); chk1("bounce_valid", key_valid, 1'b1);
        chk4("bounce_code", key_code, 4'd6);
        chk4("bounce_prev", prev_code, 4'd9);

        // Same key again after a full release.
        keys = 16'h0000;
        wait_edge(464); chk1("again_released", key_down, 1'b0);
        keys = K6;
        wait_edge(512); chk1("again_valid", key_valid, 1'b1);
        chk4("again_code", key_code, 4'd6);
        chk4("again_prev", prev_code, 4'd6);
        keys = 16'h0000;
        wait_edge(560); chk1("again_down", key_down, 1'b0);
        chki("again_strobes", strobes, 4);

        // Reset in the middle of a press debounce (cnt = 2).
        keys = K6;
        wait_edge(592);
        reset = 1'b1;
        keys  = 16'h0000;
        @(posedge clk);
        #1;
        chk4("midrst_col_n", col_n, 4'b1110);
        chk4("midrst_code", key_code, 4'd0);
        chk4("midrst_prev", prev_code, 4'd0);
        chk1("midrst_valid", key_valid, 1'b0);
        chk1("midrst_down", key_down, 1'b0);
        reset = 1'b0;
        wait_edge(32);  chk1("postrst_valid", key_valid, 1'b0);
        chki("postrst_strobes", strobes, 4);

        // Hold 6 for many frames: accepted at edge 80, repeats if enabled.
        keys = K6;
        wait_edge(80);  chk1("hold_valid", key_valid, 1'b1);
        chk4("hold_code", key_code, 4'd6);
        chk4("hold_prev", prev_code, 4'd0);
        wait_edge(96);  chk1("hold_gap", key_valid, 1'b0);
`ifdef KEYPAD_REPEAT_EN
        wait_edge(112); chk1("repeat1_valid", key_valid, 1'b1);
        chk4("repeat1_prev", prev_code, 4'd0);
        wait_edge(144); chk1("repeat2_valid", key_valid, 1'b1);
        chk4("repeat2_code", key_code, 4'd6);
        wait_edge(145); chki("repeat_strobes", strobes, 7);
`else
        wait_edge(112); chk1("norepeat1_valid", key_valid, 1'b0);
        wait_edge(144); chk1("norepeat2_valid", key_valid, 1'b0);
        chk4("norepeat_code", key_code, 4'd6);
        wait_edge(145); chki("norepeat_strobes", strobes, 5);
`endif
        chk4("final_prev", prev_code, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
